// File: rtl/wirelog_pkg.sv
// Shared types and helpers for the gate-network frame logic.
// Holds the frame FSM state enum and the step-counter width function.
package wirelog_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STEP   = 2'd2,
        FINISH = 2'd3
    } frame_state_t;

    function automatic int step_cnt_w(input int max_steps);
        return $clog2(max_steps + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
// Returns a one-hot pick, its index, and a valid flag.
module rr_arbiter_onehot #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] idx,
    output logic          valid
);

    int unsigned j;

    always_comb begin
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!valid && req[j]) begin
                valid   = 1'b1;
                pick[j] = 1'b1;
                idx     = PW'(j);
            end
        end
    end

endmodule

// File: rtl/logic_frame_scheduler.sv
// Frame sequencer for the gate network: arbitrate, clear, step until settled.
// Define LOGIC_FRAME_SCHED_WATCHDOG_EN to enforce MAX_STEPS with a timeout pulse.
module logic_frame_scheduler
    import wirelog_pkg::*;
#(
    parameter int REQ_COUNT = 4,
    parameter int MAX_STEPS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQ_COUNT-1:0] req,
    input  logic                 active,
    output logic [REQ_COUNT-1:0] grant,
    output logic                 logic_reset,
    output logic                 step_en,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);

    localparam int PW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

    frame_state_t state_q, state_d;

    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        gidx_q;
    logic [REQ_COUNT-1:0] pick;
    logic [PW-1:0]        pick_idx;
    logic                 pick_vld;
    logic                 to_d;

    rr_arbiter_onehot #(
        .N  (REQ_COUNT),
        .PW (PW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

`ifdef LOGIC_FRAME_SCHED_WATCHDOG_EN
    localparam int CW = step_cnt_w(MAX_STEPS);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = '0;
        end else if (state_q == STEP && cnt_q != CW'(MAX_STEPS)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Limit reached on this step while still changing: force the frame out.
    wire wd_hit = (cnt_q == CW'(MAX_STEPS - 1)) ||
                  (cnt_q == CW'(MAX_STEPS));
`else
    wire wd_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = STEP;
            end
            STEP: begin
                if (!active) begin
                    state_d = FINISH;
                end else if (wd_hit) begin
                    state_d = FINISH;
                    to_d    = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            gidx_q <= '0;
            grant  <= '0;
        end else begin
            if (state_q == IDLE && pick_vld) begin
                grant  <= pick;
                gidx_q <= pick_idx;
            end else if (state_q == FINISH) begin
                grant <= '0;
                if (REQ_COUNT == 1) begin
                    ptr_q <= '0;
                end else if (gidx_q == PW'(REQ_COUNT - 1)) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= gidx_q + 1'b1;
                end
            end
        end
    end

    // Outputs are flopped from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            logic_reset <= 1'b0;
            step_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            logic_reset <= (state_d == CLEAR);
            step_en     <= (state_d == STEP);
            busy        <= (state_d != IDLE);
            done        <= (state_d == FINISH);
            timeout     <= to_d;
        end
    end

endmodule

// File: tb/tb_logic_frame_scheduler.sv
// Scoreboard bench for logic_frame_scheduler: expected frames queued by
// stimulus, checked by a monitor on every done pulse.
module tb_logic_frame_scheduler;

    localparam int RC = 4;
    localparam int MS = 16;

    typedef struct {
        logic [RC-1:0] grant;
        int            steps;
        logic          to;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RC-1:0] req = '0;
    logic          active = 1'b0;
    logic [RC-1:0] grant;
    logic          logic_reset;
    logic          step_en;
    logic          busy;
    logic          done;
    logic          timeout;

    int     checks = 0;
    int     fails = 0;
    int     active_steps = 0;
    frame_t exp_q[$];

    always #5 clk = ~clk;

    logic_frame_scheduler #(
        .REQ_COUNT (RC),
        .MAX_STEPS (MS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .active      (active),
        .grant       (grant),
        .logic_reset (logic_reset),
        .step_en     (step_en),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [RC-1:0] g, input int n);
        frame_t f;
        f.grant = g;
`ifdef LOGIC_FRAME_SCHED_WATCHDOG_EN
        f.steps = (n + 1 > MS) ? MS : n + 1;
        f.to    = (n + 1 > MS);
`else
        f.steps = n + 1;
        f.to    = 1'b0;
`endif
        exp_q.push_back(f);
    endtask

    task automatic wait_dones(input int n, input int budget);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) seen++;
        end
        chk("done_wait", seen, n);
    endtask

    task automatic wait_lr(input int budget);
        int cyc = 0;
        while (!logic_reset && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("lr_wait", int'(logic_reset), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_lr"}, int'(logic_reset), 0);
        chk({tag, "_step"}, int'(step_en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_to"}, int'(timeout), 0);
    endtask

    // Drives active per step: high for the first active_steps steps.
    int steps_seen = 0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps_seen = 0;
            active = 1'b0;
        end else begin
            if (logic_reset) steps_seen = 0;
            if (step_en) begin
                active = (steps_seen < active_steps);
                steps_seen++;
            end else begin
                active = 1'b0;
            end
        end
    end

    logic [RC-1:0] fgrant;
    int  in_frame = 0;
    int  nsteps = 0;
    int  gcyc = 0;
    int  bcyc = 0;
    int  idle = 0;
    int  have_prev = 0;
    always @(negedge clk) begin
        frame_t e;
        if (!rst_n) begin
            in_frame  = 0;
            have_prev = 0;
        end else begin
            if (logic_reset) begin
                in_frame = 1;
                fgrant = grant;
                nsteps = 0;
                gcyc = 0;
                bcyc = 0;
                if (have_prev != 0) chk("idle_gap", int'(idle >= 1), 1);
            end
            if (in_frame != 0) begin
                if (grant == fgrant) gcyc++;
                if (busy) bcyc++;
                if (step_en) nsteps++;
            end
            if (timeout && !done) chk("to_without_done", 1, 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", int'(fgrant), int'(e.grant));
                    chk("steps", nsteps, e.steps);
                    chk("timeout", int'(timeout), int'(e.to));
                    chk("grant_cycles", gcyc, e.steps + 2);
                    chk("busy_cycles", bcyc, e.steps + 2);
                end
                in_frame = 0;
                idle = 0;
                have_prev = 1;
            end else if (!busy) begin
                idle++;
            end
        end
    end

    initial begin
        #1;
        chk_zero("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        active_steps = 0;
        push(4'b0001, 0);
        push(4'b0010, 0);
        push(4'b1000, 0);
        push(4'b0001, 0);
        req = 4'b1011;
        wait_dones(4, 200);
        req = '0;

        active_steps = 3;
        push(4'b1000, 3);
        req = 4'b1000;
        wait_lr(20);
        req = '0;
        wait_dones(1, 50);

        active_steps = 2;
        push(4'b0010, 2);
        req = 4'b0010;
        wait_dones(1, 50);
        req = '0;

        active_steps = 1000;
        req = 4'b1000;
        wait_lr(20);
        @(negedge clk);
        @(negedge clk);
        chk("mid_step", int'(step_en), 1);
        req = '0;
        #1 rst_n = 1'b0;
        #1 chk_zero("abort");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        active_steps = 0;
        push(4'b0001, 0);
        req = 4'b1111;
        wait_dones(1, 50);
        req = '0;

        push(4'b0100, 0);
        req = 4'b0100;
        wait_dones(1, 50);
        req = '0;

`ifdef LOGIC_FRAME_SCHED_WATCHDOG_EN
        active_steps = 1000;
        push(4'b0001, 1000);
`else
        active_steps = 40;
        push(4'b0001, 40);
`endif
        req = 4'b0001;
        wait_dones(1, 200);
        req = '0;

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk_zero("end");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/logic_frame_scheduler.md
# logic_frame_scheduler

Sequences one simulation frame of the gate network at a time. Trigger sources (switches, pressure plates, timers) raise frame requests; the scheduler grants one requester per frame in round-robin order, clears per-frame gate state with a one-cycle `logic_reset` pulse, then issues evaluation steps until the gate network reports it has settled. It sits between the trigger inputs and every `Gate_*` instance's `clk`-qualified evaluation and `logic_reset` inputs.

## Interface

- `REQ_COUNT`, 4, number of trigger requesters (≥1).
- `MAX_STEPS`, 16, step limit per frame (≥1; used only with the watchdog compiled in).
- `clk  in  1`  system clock, all logic on rising edge.
- `rst_n  in  1`  reset; asynchronous, active-low.
- `req  in  REQ_COUNT`  per-requester frame request; level, held by the requester until its grant.
- `active  in  1`  OR of gate-network change flags; high = some gate output changed this step.
- `grant  out  REQ_COUNT`  one-hot owner of the current frame; all-zero when idle.
- `logic_reset  out  1`  per-frame clear to gates; one-cycle pulse.
- `step_en  out  1`  evaluation enable to gates; one step per high cycle.
- `busy  out  1`  frame in progress (any state but IDLE).
- `done  out  1`  one-cycle pulse at frame end.
- `timeout  out  1`  one-cycle pulse coincident with `done` when the step limit ended the frame.

## Operation

- States: IDLE, CLEAR, STEP, FINISH.
- IDLE: if `req != 0`, pick the first set bit at or after the round-robin pointer (wrapping), register it into `grant`, go to CLEAR. Otherwise stay.
- CLEAR: `logic_reset=1` for exactly one cycle. Then go to STEP. The step counter loads 0.
- STEP: `step_en=1` every cycle. `active` is sampled on each STEP cycle, and the counter increments. `active==0` goes to FINISH; at least one step is always issued. With the watchdog, counter reaching `MAX_STEPS` while `active==1` goes to FINISH with timeout set.
- FINISH: `done=1` (and `timeout` if set) for one cycle. Clear `grant`, set the pointer to granted index + 1 (mod `REQ_COUNT`), return to IDLE.
- Request changes during a frame are ignored. A requester dropping `req` mid-frame does not abort the frame. The next arbitration happens only in IDLE.
- A requester still asserting `req` after its frame competes normally. Round-robin guarantees every other pending requester is served first.
- Counter width: `$clog2(MAX_STEPS+1)` bits; saturates, never wraps.
- `REQ_COUNT==1`: the pointer is constant 0, and the grant is that single requester.

## Timing

- Reset (async assert, sync deassert by the surrounding design): state IDLE, pointer 0, counter 0. All outputs are 0: `grant`, `logic_reset`, `step_en`, `busy`, `done`, `timeout`.
- Reset mid-frame aborts immediately; no `done` is generated.
- Latency from `req` sampled in IDLE to `grant` valid is 1 cycle. `logic_reset` is high in the same cycle `grant` first appears (CLEAR).
- First `step_en` comes 1 cycle after `logic_reset`.
- A frame of N steps occupies 1 (CLEAR) + N (STEP) + 1 (FINISH) cycles, with `busy` high throughout.
- Back-to-back frames have a minimum of one IDLE cycle between FINISH and the next CLEAR.
- All outputs are registered; no combinational path from `req` or `active` to any output.

## Configuration

- `LOGIC_FRAME_SCHED_WATCHDOG_EN` defined:
  - The step limit `MAX_STEPS` is enforced and the `timeout` pulse is generated.
  - This bounds oscillating gate loops (e.g. XOR feedback).
- Undefined:
  - STEP exits only on `active==0`.
  - `timeout` is tied to 0.
  - The counter logic is removed.

## Structure

- The shared package `wirelog_pkg` holds:
  - the state enum `frame_state_t` (IDLE, CLEAR, STEP, FINISH);
  - the step-counter width function.
- One sub-module: `rr_arbiter_onehot`. It is a parameterized round-robin priority picker taking `req` and the pointer and returning a one-hot pick plus valid. It is reusable by other shared-resource controllers.

## Test plan

- Single request, quick settle:
  - Stimulus: `req=4'b0010`, `active` high for 2 steps then low.
  - Response: `grant=0010` for 5 cycles, one `logic_reset` pulse, 3 `step_en` cycles, `done` pulse, then pointer=2.
- Fairness:
  - Stimulus: `req=4'b1011` held continuously.
  - Response: grants in order 0001, 0010, 1000, 0001, with ≥1 IDLE cycle between frames.
- Watchdog (macro on, `MAX_STEPS=16`):
  - Stimulus: `active` stuck high.
  - Response: exactly 16 `step_en` cycles, then `done` and `timeout` together.
- Macro off:
  - Stimulus: `active` high for 40 steps.
  - Response: 40+1 `step_en` cycles, no `timeout`.
- Reset mid-STEP:
  - Stimulus: assert `rst_n=0` during STEP.
  - Response: all outputs 0 asynchronously, no `done`, pointer 0. The next `req=0100` is granted 0100.
- Request withdrawn mid-frame:
  - Stimulus: drop `req` after `grant`.
  - Response: frame completes normally with `done`.
